deparser_layer_hs: RTL and testbench
====================================

DEPARSER_LAYER_HS -- requirements
Module: deparser_layer_hs

Interface
REQ-001 Parameters SHALL be: HEAD_WORDS, default 32, 16-bit words in head; META_WORDS, default 32, 16-bit words in meta; NUM_RULES, default 4, type rules; NUM_KEYS, default 8, replace fields per rule.
REQ-002 Ports SHALL be:
- i_clk  in  1  single clock.
- i_rst  in  1  synchronous, active-high reset.
- i_rule_wren  in  1  config write strobe.
- i_rule_rden  in  1  config read strobe.
- i_rule_addr  in  32  config address.
- i_rule_wdata  in  32  config write data.
- o_rule_rdata_valid  out  1  read data valid.
- o_rule_rdata  out  32  read data.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept a beat.
- i_head  in  HEAD_WORDS*16+TAG_WIDTH  head plus tag.
- i_meta  in  META_WORDS*16+TAG_WIDTH  meta plus tag.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts.
- o_head  out  HEAD_WORDS*16+TAG_WIDTH  processed head plus tag.
- o_meta  out  META_WORDS*16+TAG_WIDTH  shifted meta plus tag.
- o_hit  out  1  a rule matched this beat.
- o_rule_idx  out  $clog2(NUM_RULES)  index of the matched rule.
REQ-003 Word 0 SHALL be the most-significant 16 bits of the payload; byte 0 SHALL be the most-significant byte. Tag bits SHALL sit above the payload and SHALL pass through unchanged.

Function
REQ-004 Config map, i_rule_addr[10:8]:
- 1: rule addr[3:0], wdata = {mask1,mask0,data1,data0}, one byte each.
- 2: type byte offsets; wdata[7:0] = off0, wdata[15:8] = off1; shared by all rules.
- 3: rule addr[7:4], key addr[3:0]; wdata[16] = valid, wdata[13:8] = replaceOffset, wdata[5:0] = keyOffset.
- 4: rule addr[3:0]; wdata[5:0] = headShift.
- 5: rule addr[3:0]; wdata[5:0] = metaShift.
- 6: rule addr[3:0]; wdata[0] = rule valid.
- Writes to an out-of-range rule or key index SHALL be ignored.
REQ-005 A read SHALL return the same field layout, with o_rule_rdata_valid asserted one cycle after i_rule_rden. Out-of-range reads SHALL return 0.
REQ-006 A beat SHALL transfer in when i_valid && o_ready, and out when o_valid && i_ready.
REQ-007 Pipeline: stage S1 extracts type bytes at off0/off1, matches rules, and registers the beat plus a snapshot of the matched rule's fields. Stage S2 performs replace and shift and registers the outputs.
REQ-008 Latency SHALL be 2 cycles from accept to o_valid. Throughput SHALL be 1 beat per cycle while i_ready=1.
REQ-009 Stall rule: o_ready = !(S1 valid && S2 valid && !i_ready). Each stage SHALL hold while its successor is occupied and not draining. A beat SHALL never be dropped or duplicated.
REQ-010 Match condition per rule: valid && ((type0 ^ data0) & mask0) == 0 && ((type1 ^ data1) & mask1) == 0. When several rules match, the lowest index SHALL win. A type byte offset >= HEAD_WORDS*2 SHALL read as 0.
REQ-011 Hit processing, applied in order:
- For each valid key k, head word[keyOffset] := input meta word[replaceOffset], applied in ascending k so that the highest k wins on conflict.
- A key with keyOffset >= HEAD_WORDS or replaceOffset >= META_WORDS SHALL be skipped.
- Head SHALL then shift toward word 0 by headShift words, zero-filling at the tail.
- Meta SHALL shift by metaShift words, zero-filling at the tail.
- A shift >= the word count SHALL yield an all-zero payload.
REQ-012 On a miss, head and meta SHALL pass through unmodified with o_hit=0 and o_rule_idx=0.
REQ-013 A config write SHALL affect only beats accepted into S1 on a later cycle. Beats already in S1 or S2 SHALL use their snapshot.
REQ-014 A simultaneous config write and read to the same field SHALL return the old value.

Reset
REQ-015 i_rst SHALL clear all rule valid bits, key valid bits, shifts, offsets, masks and data to 0. It SHALL drive o_valid=0, o_ready=1 (next cycle), o_hit=0, o_rule_idx=0, o_rule_rdata_valid=0, o_rule_rdata=0, and o_head/o_meta=0.
REQ-016 Reset mid-traffic SHALL discard all in-flight beats with no output.

Structure
REQ-017 The rule-entry typedef (data, mask, key arrays, shifts, valid) and the config address field constants SHALL live in parser_pkg. TAG_WIDTH SHALL be taken from parser_pkg.
REQ-018 The priority match SHALL be the sub-module deparser_rule_match: combinational, taking NUM_RULES entries plus two type bytes and returning hit and idx.

Verification
REQ-019 Config: off0=12, off1=13; rule0 data={0x08,0x00}, mask={0xFF,0xFF}; key0 = (keyOffset 0, replaceOffset 0, valid); headShift=7. Stimulus: head with bytes 12,13 = 0x0800, meta word0 = 0x1111. Expect o_hit=1, o_rule_idx=0 at +2 cycles, and output head word0 = head word7 of the input with 0x1111 already applied at word 0 before the shift.
REQ-020 Miss: type 0x86DD with only rule0 (0x0800) valid. Expect o_hit=0 and o_head equal to i_head.
REQ-021 Priority: rules 1 and 2 both match 0x0800 and rule0 is invalid. Expect o_rule_idx=1.
REQ-022 Backpressure: i_ready=0 for 5 cycles during a 10-beat burst. Expect exactly 10 output beats in order, o_ready=0 only while S1 and S2 are both full and stalled, and no data change while o_valid && !i_ready.
REQ-023 Boundaries: headShift=40 with HEAD_WORDS=32 gives a zero head payload; key with keyOffset=33 is skipped; two keys with keyOffset=3 give the key1 value.
REQ-024 Reset with 2 beats in flight: no o_valid afterwards; the next beat follows the default (miss) path.

Source files
------------

// File: rtl/parser_pkg.sv
// Shared definitions for the deparser layer.
//   TAG_WIDTH     : sideband tag bits carried above the head/meta payloads
//   MAX_KEYS      : storage depth of the per-rule replace-key array
//   CFG_SEL_*     : values of the config address select field (addr[10:8])
//   key_entry_t   : one replace key (valid, meta source word, head target word)
//   rule_entry_t  : one type rule (match data/mask, keys, shifts, valid)
package parser_pkg;

   localparam int TAG_WIDTH = 8;
   localparam int MAX_KEYS  = 8;

   localparam logic [2:0] CFG_SEL_TYPE   = 3'd1;
   localparam logic [2:0] CFG_SEL_OFF    = 3'd2;
   localparam logic [2:0] CFG_SEL_KEY    = 3'd3;
   localparam logic [2:0] CFG_SEL_HSHIFT = 3'd4;
   localparam logic [2:0] CFG_SEL_MSHIFT = 3'd5;
   localparam logic [2:0] CFG_SEL_VALID  = 3'd6;

   typedef struct packed {
      logic       valid;
      logic [5:0] replace_off;
      logic [5:0] key_off;
   } key_entry_t;

   typedef struct packed {
      logic                         valid;
      logic [7:0]                   data0;
      logic [7:0]                   data1;
      logic [7:0]                   mask0;
      logic [7:0]                   mask1;
      logic [5:0]                   head_shift;
      logic [5:0]                   meta_shift;
      key_entry_t [MAX_KEYS-1:0]    keys;
   } rule_entry_t;

endpackage

// File: rtl/deparser_rule_match.sv
// Combinational priority matcher over the rule table.
//   rules_i : NUM_RULES rule entries
//   type0_i : type byte taken at offset 0
//   type1_i : type byte taken at offset 1
//   hit_o   : at least one valid rule matched
//   idx_o   : lowest matching rule index (0 on a miss)
module deparser_rule_match
   import parser_pkg::*;
#(
   parameter int NUM_RULES = 4,
   parameter int IDX_W     = $clog2(NUM_RULES)
) (
   input  rule_entry_t [NUM_RULES-1:0] rules_i,
   input  logic [7:0]                  type0_i,
   input  logic [7:0]                  type1_i,
   output logic                        hit_o,
   output logic [IDX_W-1:0]            idx_o
);

   // Scan from the top down so the lowest matching index is written last.
   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      for (int r = NUM_RULES - 1; r >= 0; r--) begin
         if (rules_i[r].valid &&
             (((type0_i ^ rules_i[r].data0) & rules_i[r].mask0) == 8'h00) &&
             (((type1_i ^ rules_i[r].data1) & rules_i[r].mask1) == 8'h00)) begin
            hit_o = 1'b1;
            idx_o = IDX_W'(r);
         end
      end
   end

endmodule

// File: rtl/deparser_layer_hs.sv
// Two-stage deparser layer with valid/ready handshake.
// S1 picks two type bytes out of the head, matches them against the rule
// table and captures the beat with a snapshot of the winning rule's keys and
// shifts. S2 applies meta->head word replacement, then shifts head and meta
// toward word 0, and registers the result.
//   i_clk / i_rst                 : clock, synchronous active-high reset
//   i_rule_wren/rden/addr/wdata   : config access (addr[10:8] selects field)
//   o_rule_rdata_valid/rdata      : read response, one cycle after rden
//   i_valid / o_ready / i_head / i_meta   : input beat (tag above payload)
//   o_valid / i_ready / o_head / o_meta   : output beat
//   o_hit / o_rule_idx            : match result travelling with the beat
// NUM_RULES is expected in 2..16 and NUM_KEYS in 1..MAX_KEYS.
module deparser_layer_hs
   import parser_pkg::*;
#(
   parameter int HEAD_WORDS = 32,
   parameter int META_WORDS = 32,
   parameter int NUM_RULES  = 4,
   parameter int NUM_KEYS   = 8
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_rule_wren,
   input  logic                               i_rule_rden,
   input  logic [31:0]                        i_rule_addr,
   input  logic [31:0]                        i_rule_wdata,
   output logic                               o_rule_rdata_valid,
   output logic [31:0]                        o_rule_rdata,
   input  logic                               i_valid,
   output logic                               o_ready,
   input  logic [HEAD_WORDS*16+TAG_WIDTH-1:0] i_head,
   input  logic [META_WORDS*16+TAG_WIDTH-1:0] i_meta,
   output logic                               o_valid,
   input  logic                               i_ready,
   output logic [HEAD_WORDS*16+TAG_WIDTH-1:0] o_head,
   output logic [META_WORDS*16+TAG_WIDTH-1:0] o_meta,
   output logic                               o_hit,
   output logic [$clog2(NUM_RULES)-1:0]       o_rule_idx
);

   localparam int HP     = HEAD_WORDS * 16;
   localparam int MP     = META_WORDS * 16;
   localparam int HB     = HP + TAG_WIDTH;
   localparam int MB     = MP + TAG_WIDTH;
   localparam int IDX_W  = $clog2(NUM_RULES);
   localparam int NK     = (NUM_KEYS < MAX_KEYS) ? NUM_KEYS : MAX_KEYS;
   localparam int KEY_IW = $clog2(MAX_KEYS);

   // Byte 0 is the MSB byte; offsets past the payload shift everything out and read as 0.
   function automatic logic [7:0] head_byte(input logic [HP-1:0] p, input logic [7:0] off);
      logic [HP-1:0] t;
      t = p << {off, 3'b000};
      return t[HP-1 -: 8];
   endfunction

   // Ascending key order: a later key overwrites an earlier one on the same word.
   function automatic logic [HP-1:0] apply_keys(input logic [HP-1:0]           h,
                                                input logic [MP-1:0]           m,
                                                input key_entry_t [MAX_KEYS-1:0] keys);
      logic [HP-1:0] r;
      r = h;
      for (int k = 0; k < NK; k++) begin
         if (keys[k].valid &&
             (int'(keys[k].key_off) < HEAD_WORDS) &&
             (int'(keys[k].replace_off) < META_WORDS)) begin
            r[HP-1-16*int'(keys[k].key_off) -: 16] = m[MP-1-16*int'(keys[k].replace_off) -: 16];
         end
      end
      return r;
   endfunction

   rule_entry_t [NUM_RULES-1:0] rules_q;
   logic [7:0]                  off0_q, off1_q;
   logic [31:0]                 rdata_d, rdata_q;
   logic                        rvld_q;

   // Any address bit above the select field makes the access a no-op.
   logic                        addr_ok;
   logic [2:0]                  cfg_sel;
   logic [3:0]                  rule_lo, rule_hi, key_a;
   logic                        lo_ok, hi_ok, key_ok;
   logic [IDX_W-1:0]            lo_idx, hi_idx;
   logic [KEY_IW-1:0]           key_idx;
   rule_entry_t                 r_lo, r_hi;
   key_entry_t                  k_sel;

   assign addr_ok = (i_rule_addr[31:11] == 21'd0);
   assign cfg_sel = i_rule_addr[10:8];
   assign rule_lo = i_rule_addr[3:0];
   assign rule_hi = i_rule_addr[7:4];
   assign key_a   = i_rule_addr[3:0];
   assign lo_ok   = int'(rule_lo) < NUM_RULES;
   assign hi_ok   = int'(rule_hi) < NUM_RULES;
   assign key_ok  = int'(key_a) < NK;
   assign lo_idx  = rule_lo[IDX_W-1:0];
   assign hi_idx  = rule_hi[IDX_W-1:0];
   assign key_idx = key_a[KEY_IW-1:0];
   assign r_lo    = rules_q[lo_idx];
   assign r_hi    = rules_q[hi_idx];
   assign k_sel   = r_hi.keys[key_idx];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rules_q <= '0;
         off0_q  <= '0;
         off1_q  <= '0;
      end else if (i_rule_wren && addr_ok) begin
         case (cfg_sel)
            CFG_SEL_TYPE: if (lo_ok) begin
               rules_q[lo_idx].mask1 <= i_rule_wdata[31:24];
               rules_q[lo_idx].mask0 <= i_rule_wdata[23:16];
               rules_q[lo_idx].data1 <= i_rule_wdata[15:8];
               rules_q[lo_idx].data0 <= i_rule_wdata[7:0];
            end
            CFG_SEL_OFF: begin
               off0_q <= i_rule_wdata[7:0];
               off1_q <= i_rule_wdata[15:8];
            end
            CFG_SEL_KEY: if (hi_ok && key_ok) begin
               rules_q[hi_idx].keys[key_idx].valid       <= i_rule_wdata[16];
               rules_q[hi_idx].keys[key_idx].replace_off <= i_rule_wdata[13:8];
               rules_q[hi_idx].keys[key_idx].key_off     <= i_rule_wdata[5:0];
            end
            CFG_SEL_HSHIFT: if (lo_ok) rules_q[lo_idx].head_shift <= i_rule_wdata[5:0];
            CFG_SEL_MSHIFT: if (lo_ok) rules_q[lo_idx].meta_shift <= i_rule_wdata[5:0];
            CFG_SEL_VALID:  if (lo_ok) rules_q[lo_idx].valid      <= i_rule_wdata[0];
            default: ;
         endcase
      end
   end

   // Reads sample the table before any same-cycle write lands.
   always_comb begin
      rdata_d = '0;
      if (addr_ok) begin
         case (cfg_sel)
            CFG_SEL_TYPE:   if (lo_ok) rdata_d = {r_lo.mask1, r_lo.mask0, r_lo.data1, r_lo.data0};
            CFG_SEL_OFF:    rdata_d = {16'd0, off1_q, off0_q};
            CFG_SEL_KEY:    if (hi_ok && key_ok)
                               rdata_d = {15'd0, k_sel.valid, 2'b00, k_sel.replace_off,
                                          2'b00, k_sel.key_off};
            CFG_SEL_HSHIFT: if (lo_ok) rdata_d = {26'd0, r_lo.head_shift};
            CFG_SEL_MSHIFT: if (lo_ok) rdata_d = {26'd0, r_lo.meta_shift};
            CFG_SEL_VALID:  if (lo_ok) rdata_d = {31'd0, r_lo.valid};
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rvld_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         rvld_q <= i_rule_rden;
         if (i_rule_rden) rdata_q <= rdata_d;
      end
   end

   assign o_rule_rdata_valid = rvld_q;
   assign o_rule_rdata       = rdata_q;

   logic                      vld_p1_q, vld_p2_q;
   logic                      s2_adv;
   logic [7:0]                type0, type1;
   logic                      m_hit;
   logic [IDX_W-1:0]          m_idx;

   assign s2_adv  = !vld_p2_q || i_ready;
   assign o_ready = !(vld_p1_q && vld_p2_q && !i_ready);
   assign type0   = head_byte(i_head[HP-1:0], off0_q);
   assign type1   = head_byte(i_head[HP-1:0], off1_q);

   deparser_rule_match #(
      .NUM_RULES (NUM_RULES),
      .IDX_W     (IDX_W)
   ) u_match (
      .rules_i (rules_q),
      .type0_i (type0),
      .type1_i (type1),
      .hit_o   (m_hit),
      .idx_o   (m_idx)
   );

   // ---- S1: beat capture plus rule snapshot ----
   logic [HB-1:0]             head_p1_q;
   logic [MB-1:0]             meta_p1_q;
   logic                      hit_p1_q;
   logic [IDX_W-1:0]          idx_p1_q;
   key_entry_t [MAX_KEYS-1:0] keys_p1_q;
   logic [5:0]                hsh_p1_q, msh_p1_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) vld_p1_q <= 1'b0;
      else if (o_ready) vld_p1_q <= i_valid;
   end

   // A miss snapshots an empty rule so S2 degenerates to a pass-through.
   always_ff @(posedge i_clk) begin
      if (o_ready && i_valid) begin
         head_p1_q <= i_head;
         meta_p1_q <= i_meta;
         hit_p1_q  <= m_hit;
         idx_p1_q  <= m_hit ? m_idx : '0;
         keys_p1_q <= m_hit ? rules_q[m_idx].keys : '0;
         hsh_p1_q  <= m_hit ? rules_q[m_idx].head_shift : 6'd0;
         msh_p1_q  <= m_hit ? rules_q[m_idx].meta_shift : 6'd0;
      end
   end

   // ---- S2: replace, shift, output registers ----
   logic [HP-1:0]             head_rep;
   logic [HB-1:0]             head_d;
   logic [MB-1:0]             meta_d;
   logic [HB-1:0]             head_p2_q;
   logic [MB-1:0]             meta_p2_q;
   logic                      hit_p2_q;
   logic [IDX_W-1:0]          idx_p2_q;

   // Left shift moves words toward word 0 and zero-fills the tail; a shift
   // of the full word count or more clears the payload outright.
   assign head_rep = apply_keys(head_p1_q[HP-1:0], meta_p1_q[MP-1:0], keys_p1_q);
   assign head_d   = {head_p1_q[HB-1:HP], head_rep << {hsh_p1_q, 4'b0000}};
   assign meta_d   = {meta_p1_q[MB-1:MP], meta_p1_q[MP-1:0] << {msh_p1_q, 4'b0000}};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_p2_q  <= 1'b0;
         head_p2_q <= '0;
         meta_p2_q <= '0;
         hit_p2_q  <= 1'b0;
         idx_p2_q  <= '0;
      end else if (s2_adv) begin
         vld_p2_q <= vld_p1_q;
         if (vld_p1_q) begin
            head_p2_q <= head_d;
            meta_p2_q <= meta_d;
            hit_p2_q  <= hit_p1_q;
            idx_p2_q  <= idx_p1_q;
         end
      end
   end

   assign o_valid    = vld_p2_q;
   assign o_head     = head_p2_q;
   assign o_meta     = meta_p2_q;
   assign o_hit      = hit_p2_q;
   assign o_rule_idx = idx_p2_q;

endmodule

// File: tb/tb_deparser_layer_hs.sv
// Directed self-checking bench for deparser_layer_hs (default parameters).
module tb_deparser_layer_hs;
   import parser_pkg::*;

   localparam int HW = 32;
   localparam int MW = 32;
   localparam int HP = HW * 16;
   localparam int MP = MW * 16;
   localparam int HB = HP + TAG_WIDTH;
   localparam int MB = MP + TAG_WIDTH;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_rule_wren, i_rule_rden;
   logic [31:0]   i_rule_addr, i_rule_wdata;
   logic          o_rule_rdata_valid;
   logic [31:0]   o_rule_rdata;
   logic          i_valid, o_ready, o_valid, i_ready, o_hit;
   logic [HB-1:0] i_head, o_head;
   logic [MB-1:0] i_meta, o_meta;
   logic [1:0]    o_rule_idx;

   int            vectors = 0;
   int            miscompares = 0;
   int            sent, got;
   logic          acc, dlv, stall_prev;
   logic [HB-1:0] held_h, exp_h, hA;
   logic [MB-1:0] held_m, exp_m, mA;

   deparser_layer_hs #(
      .HEAD_WORDS (HW),
      .META_WORDS (MW),
      .NUM_RULES  (4),
      .NUM_KEYS   (8)
   ) dut (
      .i_clk              (i_clk),
      .i_rst              (i_rst),
      .i_rule_wren        (i_rule_wren),
      .i_rule_rden        (i_rule_rden),
      .i_rule_addr        (i_rule_addr),
      .i_rule_wdata       (i_rule_wdata),
      .o_rule_rdata_valid (o_rule_rdata_valid),
      .o_rule_rdata       (o_rule_rdata),
      .i_valid            (i_valid),
      .o_ready            (o_ready),
      .i_head             (i_head),
      .i_meta             (i_meta),
      .o_valid            (o_valid),
      .i_ready            (i_ready),
      .o_head             (o_head),
      .o_meta             (o_meta),
      .o_hit              (o_hit),
      .o_rule_idx         (o_rule_idx)
   );

   always #5 i_clk = ~i_clk;

   task automatic check1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkw(input string tag, input logic [HB-1:0] obs, input logic [HB-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [HB-1:0] put_hw(input logic [HB-1:0] h, input int w, input logic [15:0] v);
      h[HP-1-16*w -: 16] = v;
      return h;
   endfunction

   function automatic logic [MB-1:0] put_mw(input logic [MB-1:0] m, input int w, input logic [15:0] v);
      m[MP-1-16*w -: 16] = v;
      return m;
   endfunction

   // Words base+w, word 6 (bytes 12/13) overridden with the type value.
   function automatic logic [HB-1:0] mk_head(input logic [15:0] base, input logic [15:0] type_w,
                                             input logic [TAG_WIDTH-1:0] tag);
      logic [HB-1:0] h;
      h = '0;
      h[HB-1 -: TAG_WIDTH] = tag;
      for (int w = 0; w < HW; w++) h = put_hw(h, w, base + 16'(w));
      h = put_hw(h, 6, type_w);
      return h;
   endfunction

   function automatic logic [MB-1:0] mk_meta(input logic [15:0] base, input logic [TAG_WIDTH-1:0] tag);
      logic [MB-1:0] m;
      m = '0;
      m[MB-1 -: TAG_WIDTH] = tag;
      for (int w = 0; w < MW; w++) m = put_mw(m, w, base + 16'(w));
      return m;
   endfunction

   function automatic logic [HB-1:0] burst_head(input int idx);
      return put_hw(mk_head(16'hC000, 16'h1234, TAG_WIDTH'(idx)), 0, 16'(idx));
   endfunction

   function automatic logic [MB-1:0] burst_meta(input int idx);
      return put_mw(mk_meta(16'hD000, TAG_WIDTH'(idx)), 0, 16'(idx));
   endfunction

   task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
      i_rule_wren = 1'b1; i_rule_addr = a; i_rule_wdata = d;
      @(posedge i_clk); #1;
      i_rule_wren = 1'b0;
   endtask

   task automatic cfg_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      i_rule_rden = 1'b1; i_rule_addr = a;
      @(posedge i_clk); #1;
      i_rule_rden = 1'b0;
      check1({tag, "_vld"}, o_rule_rdata_valid, 1'b1);
      check32(tag, o_rule_rdata, exp);
   endtask

   // Accept on the first edge, result visible after the second.
   task automatic send(input logic [HB-1:0] h, input logic [MB-1:0] m);
      i_valid = 1'b1; i_head = h; i_meta = m;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      @(posedge i_clk); #1;
   endtask

   initial begin
      i_rst = 1'b1; i_rule_wren = 1'b0; i_rule_rden = 1'b0;
      i_rule_addr = '0; i_rule_wdata = '0;
      i_valid = 1'b0; i_ready = 1'b1; i_head = '0; i_meta = '0;
      repeat (2) begin @(posedge i_clk); #1; end

      // Reset state
      check1("rst_o_valid", o_valid, 1'b0);
      check1("rst_o_ready", o_ready, 1'b1);
      check1("rst_o_hit", o_hit, 1'b0);
      check32("rst_o_rule_idx", 32'(o_rule_idx), 32'd0);
      check1("rst_rdata_valid", o_rule_rdata_valid, 1'b0);
      check32("rst_rdata", o_rule_rdata, 32'd0);
      checkw("rst_o_head", o_head, '0);
      checkw("rst_o_meta", o_meta, '0);
      i_rst = 1'b0;
      @(posedge i_clk); #1;

      // Basic hit configuration
      cfg_wr(32'h0000_0200, 32'h0000_0D0C);
      cfg_wr(32'h0000_0100, 32'hFFFF_0008);
      cfg_wr(32'h0000_0300, 32'h0001_0000);
      cfg_wr(32'h0000_0400, 32'd7);
      cfg_wr(32'h0000_0600, 32'd1);
      cfg_wr(32'h0000_0104, 32'h1234_5678);
      cfg_rd("rd_type0", 32'h0000_0100, 32'hFFFF_0008);
      cfg_rd("rd_offs", 32'h0000_0200, 32'h0000_0D0C);
      cfg_rd("rd_key00", 32'h0000_0300, 32'h0001_0000);
      cfg_rd("rd_oor_rule", 32'h0000_0105, 32'h0000_0000);

      // Hit: key0 puts 0x1111 into word 0, then head shifts by 7 words
      hA = mk_head(16'hA000, 16'h0800, 8'h3C);
      mA = mk_meta(16'h1111, 8'hC3);
      send(hA, mA);
      exp_h = '0;
      exp_h[HB-1 -: TAG_WIDTH] = 8'h3C;
      for (int j = 0; j < HW - 7; j++) exp_h = put_hw(exp_h, j, 16'hA000 + 16'(j + 7));
      check1("hit_o_valid", o_valid, 1'b1);
      check1("hit_o_hit", o_hit, 1'b1);
      check32("hit_o_rule_idx", 32'(o_rule_idx), 32'd0);
      checkw("hit_o_head", o_head, exp_h);
      checkw("hit_o_meta", o_meta, mA);
      @(posedge i_clk); #1;
      check1("hit_drained", o_valid, 1'b0);

      // Same-cycle write and read of one field returns the old value
      i_rule_wren = 1'b1; i_rule_rden = 1'b1;
      i_rule_addr = 32'h0000_0400; i_rule_wdata = 32'd9;
      @(posedge i_clk); #1;
      i_rule_wren = 1'b0; i_rule_rden = 1'b0;
      check32("wr_rd_old", o_rule_rdata, 32'd7);
      cfg_rd("wr_rd_new", 32'h0000_0400, 32'd9);

      // Miss
      hA = mk_head(16'h2000, 16'h86DD, 8'h11);
      mA = mk_meta(16'h4000, 8'h12);
      send(hA, mA);
      check1("miss_o_valid", o_valid, 1'b1);
      check1("miss_o_hit", o_hit, 1'b0);
      check32("miss_o_rule_idx", 32'(o_rule_idx), 32'd0);
      checkw("miss_o_head", o_head, hA);
      checkw("miss_o_meta", o_meta, mA);

      // Priority: rules 1 and 2 both match, rule 0 disabled
      cfg_wr(32'h0000_0101, 32'hFFFF_0008);
      cfg_wr(32'h0000_0102, 32'hFFFF_0008);
      cfg_wr(32'h0000_0402, 32'd5);
      cfg_wr(32'h0000_0601, 32'd1);
      cfg_wr(32'h0000_0602, 32'd1);
      cfg_wr(32'h0000_0600, 32'd0);
      hA = mk_head(16'h3000, 16'h0800, 8'h22);
      mA = mk_meta(16'h5000, 8'h23);
      send(hA, mA);
      check1("prio_o_hit", o_hit, 1'b1);
      check32("prio_o_rule_idx", 32'(o_rule_idx), 32'd1);
      checkw("prio_o_head", o_head, hA);

      // Head shift beyond the word count clears the payload, tag survives
      cfg_wr(32'h0000_0401, 32'd40);
      hA = mk_head(16'hE000, 16'h0800, 8'h5A);
      send(hA, mA);
      exp_h = '0;
      exp_h[HB-1 -: TAG_WIDTH] = 8'h5A;
      check1("big_shift_o_hit", o_hit, 1'b1);
      checkw("big_shift_o_head", o_head, exp_h);

      // Two keys on word 3 (key1 wins), key2 aimed past the head is skipped,
      // meta shifted by 2 after its original words fed the replace
      cfg_wr(32'h0000_0401, 32'd0);
      cfg_wr(32'h0000_0501, 32'd2);
      cfg_wr(32'h0000_0310, 32'h0001_0103);
      cfg_wr(32'h0000_0311, 32'h0001_0203);
      cfg_wr(32'h0000_0312, 32'h0001_0021);
      cfg_wr(32'h0000_0319, 32'h0001_003F);
      cfg_rd("rd_key11", 32'h0000_0311, 32'h0001_0203);
      hA = mk_head(16'hE000, 16'h0800, 8'h5B);
      mA = mk_meta(16'hB000, 8'hA5);
      send(hA, mA);
      exp_h = put_hw(hA, 3, 16'hB002);
      exp_m = '0;
      exp_m[MB-1 -: TAG_WIDTH] = 8'hA5;
      for (int j = 0; j < MW - 2; j++) exp_m = put_mw(exp_m, j, 16'hB000 + 16'(j + 2));
      check32("keys_o_rule_idx", 32'(o_rule_idx), 32'd1);
      checkw("keys_o_head", o_head, exp_h);
      checkw("keys_o_meta", o_meta, exp_m);
      @(posedge i_clk); #1;

      // 10-beat burst of misses with downstream stalled for cycles 3..7
      sent = 0; got = 0; stall_prev = 1'b0;
      for (int c = 0; c < 60 && got < 10; c++) begin
         i_ready = !(c >= 3 && c < 8);
         i_valid = (sent < 10);
         i_head  = burst_head(sent);
         i_meta  = burst_meta(sent);
         #1;
         if (stall_prev) begin
            checkw("stall_hold_head", o_head, held_h);
            checkw("stall_hold_meta", o_meta, held_m);
         end
         check1("burst_o_ready", o_ready, !(((sent - got) == 2) && !i_ready));
         acc = i_valid && o_ready;
         dlv = o_valid && i_ready;
         if (dlv) begin
            checkw("burst_o_head", o_head, burst_head(got));
            checkw("burst_o_meta", o_meta, burst_meta(got));
         end
         stall_prev = o_valid && !i_ready;
         held_h = o_head;
         held_m = o_meta;
         @(posedge i_clk); #1;
         if (acc) sent++;
         if (dlv) got++;
      end
      i_valid = 1'b0; i_ready = 1'b1;
      check32("burst_count", got, 32'd10);
      @(posedge i_clk); #1;
      check1("burst_drained", o_valid, 1'b0);

      // Reset with two beats in flight
      i_valid = 1'b1; i_head = mk_head(16'h6000, 16'h0800, 8'h61); i_meta = mk_meta(16'h7000, 8'h62);
      @(posedge i_clk); #1;
      i_head = mk_head(16'h6100, 16'h0800, 8'h63);
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_ready = 1'b0; i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0; i_ready = 1'b1;
      check1("midrst_o_valid", o_valid, 1'b0);
      check1("midrst_o_ready", o_ready, 1'b1);
      checkw("midrst_o_head", o_head, '0);
      for (int c = 0; c < 3; c++) begin
         @(posedge i_clk); #1;
         check1("post_rst_o_valid", o_valid, 1'b0);
      end
      cfg_rd("post_rst_valid1", 32'h0000_0601, 32'd0);
      cfg_rd("post_rst_type1", 32'h0000_0101, 32'd0);
      hA = mk_head(16'h8000, 16'h0800, 8'h71);
      mA = mk_meta(16'h9000, 8'h72);
      send(hA, mA);
      check1("post_rst_beat_valid", o_valid, 1'b1);
      check1("post_rst_o_hit", o_hit, 1'b0);
      check32("post_rst_o_rule_idx", 32'(o_rule_idx), 32'd0);
      checkw("post_rst_o_head", o_head, hA);
      checkw("post_rst_o_meta", o_meta, mA);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
